mac_accumulator: RTL

//   Accumulation stage of the MAC unit. Consumes a stream of signed products,

---
 rtl/mac_accumulator.sv | 115 +++++++++++
 1 files changed

// File: rtl/mac_accumulator.sv
// Accumulation stage of the MAC unit: sums VEC_LEN signed products into a
// wide accumulator. Each finished dot-product is offered on a valid/ready
// output, with an optional clamp and a sticky overflow flag for the vector.
module mac_accumulator #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 40,
  parameter int VEC_LEN   = 8,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output logic                        out_overflow
);

  localparam int CNT_W = $clog2(VEC_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VEC_LEN - 1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                       state;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic [CNT_W-1:0]             count;
  logic                         ovf;

  logic signed [ACC_WIDTH:0]    in_ext;
  logic signed [ACC_WIDTH:0]    sum;
  logic signed [ACC_WIDTH-1:0]  sum_adj;
  logic                         sum_ovf;
  logic                         beat;

  // The guard bit of the one-bit-wider sum disagrees with the sign bit
  // exactly when the true sum does not fit in ACC_WIDTH bits.
  function automatic logic sum_overflow(input logic signed [ACC_WIDTH:0] s);
    return s[ACC_WIDTH] ^ s[ACC_WIDTH-1];
  endfunction

  // Clamp to the representable range, or plain two's-complement wrap.
  function automatic logic signed [ACC_WIDTH-1:0] saturate_sum(
    input logic signed [ACC_WIDTH:0] s
  );
    if (SATURATE && (s[ACC_WIDTH] != s[ACC_WIDTH-1]))
      return s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    return s[ACC_WIDTH-1:0];
  endfunction

  // in_ready depends on the state register alone, keeping out_ready off
  // any combinational path back to the producer.
  assign in_ready = (state == ACCUM);
  assign beat     = in_valid & in_ready;

  // Candidate next accumulator value for an accepted product.
  always_comb begin
    in_ext  = {{(ACC_WIDTH + 1 - IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
    sum     = {acc[ACC_WIDTH-1], acc} + in_ext;
    sum_adj = saturate_sum(sum);
    sum_ovf = sum_overflow(sum);
  end

  // Accumulate/hold control; clear discards any partial or held result
  // but leaves out_data showing the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ACCUM;
      acc          <= '0;
      count        <= '0;
      ovf          <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_overflow <= 1'b0;
    end else if (clear) begin
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (beat) begin
            if (count == LAST_BEAT) begin
              out_data     <= sum_adj;
              out_overflow <= ovf | sum_ovf;
              out_valid    <= 1'b1;
              acc          <= '0;
              count        <= '0;
              ovf          <= 1'b0;
              state        <= HOLD;
            end else begin
              acc   <= sum_adj;
              count <= count + CNT_W'(1);
              ovf   <= ovf | sum_ovf;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
